// File: rtl/cpu_defs.sv
// Shared CPU definitions: register file geometry and address type.
package cpu_defs;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned REG_DW  = 32;
  localparam int unsigned REG_NUM = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_rport.sv
// One register file read port: enable, zero-index, optional same-cycle
// write bypass, then array data. Bypass selected by REGFILE_BYPASS_EN.
module regfile_rport
  import cpu_defs::*;
#(
  parameter int unsigned AW = REG_AW,
  parameter int unsigned DW = REG_DW
) (
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] arr_data,
  output logic [DW-1:0] rdata
);

`ifndef REGFILE_BYPASS_EN
  // Write-port signals only feed the bypass; keep them referenced.
  logic unused_bypass;
  assign unused_bypass = ^{we, waddr, wdata};
`endif

  // Priority mux: disabled / r0 read zero, bypass beats the array.
  always_comb begin
    rdata = arr_data;
    if (!re) begin
      rdata = '0;
    end else if (raddr == AW'(0)) begin
      rdata = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (we && (waddr == raddr)) begin
      rdata = wdata;
`endif
    end
  end

endmodule

// File: rtl/regfile.sv
// General-purpose register file: one write port from MEM/WB, two
// combinational read ports for ID. r0 has no storage and reads zero.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile
  import cpu_defs::*;
#(
  parameter int unsigned NREG = REG_NUM,
  parameter int unsigned AW   = REG_AW,
  parameter int unsigned DW   = REG_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] regs [1:NREG-1];
  logic [DW-1:0] arr1;
  logic [DW-1:0] arr2;

  // Array write; r0 writes are dropped, reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != AW'(0))) begin
      regs[waddr] <= wdata;
    end
  end

  // Array lookup per port; index 0 falls through to zero.
  always_comb begin
    arr1 = '0;
    arr2 = '0;
    for (int i = 1; i < int'(NREG); i++) begin
      if (raddr1 == AW'(i)) arr1 = regs[i];
      if (raddr2 == AW'(i)) arr2 = regs[i];
    end
  end

  regfile_rport #(.AW(AW), .DW(DW)) u_rport1 (
    .re       (re1),
    .raddr    (raddr1),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .arr_data (arr1),
    .rdata    (rdata1)
  );

  regfile_rport #(.AW(AW), .DW(DW)) u_rport2 (
    .re       (re2),
    .raddr    (raddr2),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .arr_data (arr2),
    .rdata    (rdata2)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile; adapts expectations to REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module tb_regfile;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  logic [31:0] model [0:31];
  logic [31:0] exp_q [$];
  string       tag_q [$];
  int          errors;
  int          checks;

  regfile dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference read value from the bench's own register model.
  function automatic logic [31:0] ref_rd(input logic re, input logic [4:0] a);
    if (!re || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic check_one(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  // Drive both read ports, queue expectations, compare 1ns later.
  task automatic read2(input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2, input string tag);
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
    exp_q.push_back(ref_rd(r1, a1));
    tag_q.push_back($sformatf("%s_p1_r%0d", tag, a1));
    exp_q.push_back(ref_rd(r2, a2));
    tag_q.push_back($sformatf("%s_p2_r%0d", tag, a2));
    #1;
    check_one(rdata1);
    check_one(rdata2);
  endtask

  // One write cycle: set up at negedge, commit at posedge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clk);
    if (rst_n && a != 5'd0) model[a] = d;
    #1;
    we = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    clear_model();

    // Asynchronous reset before any clock edge; reads live immediately.
    #2 rst_n = 1'b0;
    for (int a = 1; a < 32; a++) read2(1'b1, 5'(a), 1'b1, 5'(32 - a), "por");
    @(negedge clk) rst_n = 1'b1;

    // Basic write then read, and read-enable gating.
    do_write(5'd5, 32'hDEADBEEF);
    read2(1'b1, 5'd5, 1'b1, 5'd5, "wr5");
    read2(1'b0, 5'd5, 1'b1, 5'd6, "re_off");

    // r0 is immutable, also during the write cycle itself.
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    read2(1'b1, 5'd0, 1'b1, 5'd0, "r0_wr");
    @(posedge clk); #1 we = 1'b0;
    read2(1'b1, 5'd0, 1'b1, 5'd0, "r0_after");

    // Same-cycle write/read hazard on r7.
    do_write(5'd7, 32'h11);
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h22;
    read2(1'b1, 5'd7, 1'b1, 5'd7, "haz_pre");
    read2(1'b1, 5'd5, 1'b1, 5'd7, "haz_mix");
    @(posedge clk);
    model[7] = 32'h22;
    #1 we = 1'b0;
    read2(1'b1, 5'd7, 1'b1, 5'd7, "haz_post");

    // Back-to-back writes to one index; top index.
    do_write(5'd9, 32'hAAAA0001);
    do_write(5'd9, 32'hBBBB0002);
    do_write(5'd31, 32'hC0FFEE31);
    read2(1'b1, 5'd9, 1'b1, 5'd31, "b2b_top");

    // Fill r1..r31 with their own index and verify.
    for (int a = 1; a < 32; a++) do_write(5'(a), 32'(a));
    for (int a = 1; a < 32; a++) read2(1'b1, 5'(a), 1'b1, 5'(32 - a), "fill");

    // Reset dropped between edges while a write to r3 is pending.
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 32'h99;
    #2 rst_n = 1'b0;
    clear_model();
    for (int a = 1; a < 32; a++) read2(1'b1, 5'(a), 1'b1, 5'(32 - a), "mid_rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    model[3] = 32'h99;
    #1 we = 1'b0;
    for (int a = 1; a < 32; a++) read2(1'b1, 5'(a), 1'b1, 5'(32 - a), "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
